// File: rtl/pixel_clip_fifo_pkg.sv
// Shared types and constants for the pixel clip/buffer path to the VGA adapter.
// Screen geometry, colour constants, FIFO entry layout and the done-tracking states.
package pixel_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;

   localparam logic [2:0] BLACK = 3'b000;
   localparam logic [2:0] WHITE = 3'b111;

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] colour;
   } pixel_t;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

   // Signed compare of generator coordinates against the visible window.
   function automatic logic is_clipped(input logic [8:0] x, input logic [7:0] y,
                                       input int w, input int h);
      int sx;
      int sy;
      sx = int'($signed(x));
      sy = int'($signed(y));
      return (sx < 0) || (sx >= w) || (sy < 0) || (sy >= h);
   endfunction

endpackage

// File: rtl/pixel_clip_fifo_sync_fifo.sv
// Single-clock FIFO with combinational head read and an occupancy count.
// Pointers wrap naturally because DEPTH is a power of two.
module sync_fifo #(
   parameter int W     = 18,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic [W-1:0]               i_wdata,
   input  logic                       i_pop,
   output logic [W-1:0]               o_rdata,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [CW-1:0] r_cnt;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_cnt == CW'(DEPTH));
   assign o_empty = (r_cnt == '0);
   assign o_count = r_cnt;
   assign o_rdata = r_mem[r_rd];
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + AW'(1);
         if (w_pop)  r_rd <= r_rd + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= i_wdata;
   end

endmodule

// File: rtl/pixel_clip_fifo.sv
// Clips signed plot requests to the screen, buffers on-screen pixels and drains
// them to the VGA plot port, pulsing done after the final strobe of a drawing.
module pixel_clip_fifo
   import pixel_pkg::*;
#(
   parameter int DEPTH    = 8,
   parameter int SCREEN_W = pixel_pkg::SCREEN_W,
   parameter int SCREEN_H = pixel_pkg::SCREEN_H
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [8:0]  in_x,
   input  logic [7:0]  in_y,
   input  logic [2:0]  in_colour,
   input  logic        in_last,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        out_en,
   output logic [7:0]  vga_x,
   output logic [6:0]  vga_y,
   output logic [2:0]  vga_colour,
   output logic        vga_plot,
   output logic        done,
   output logic [15:0] clip_count
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic          w_clip, w_acc, w_push, w_pop, w_full, w_empty;
   logic          w_lp_nxt, w_done_nxt;
   logic [CW-1:0] w_count, w_cnt_nxt;
   pixel_t        w_wpix, w_head, r_s1, r_vga;
   logic [1:0]    r_vld_pipe;
   logic [15:0]   r_clip_cnt;
   logic          r_last_pend, r_done;
   state_t        r_state;

   assign w_clip = is_clipped(in_x, in_y, SCREEN_W, SCREEN_H);
   assign w_acc  = in_valid & in_ready;
   assign w_push = w_acc & ~w_clip;
   assign w_pop  = out_en & ~w_empty;
   assign w_wpix = '{x: in_x[7:0], y: in_y[6:0], colour: in_colour};

   sync_fifo #(.W($bits(pixel_t)), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_wdata (w_wpix),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // in_ready follows the registered occupancy, so a pop on a full FIFO frees a slot next cycle.
   assign in_ready = ~w_full;

   // done is registered by predicting next-cycle occupancy, pop stage and strobe.
   assign w_cnt_nxt  = w_count + CW'(w_push) - CW'(w_pop);
   assign w_lp_nxt   = (r_last_pend & (r_state != S_DONE)) | (w_acc & in_last);
   assign w_done_nxt = w_lp_nxt && (w_cnt_nxt == '0) && !w_pop && !r_vld_pipe[0]
                       && (r_state != S_DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_last_pend <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_last_pend <= w_lp_nxt;
         r_done      <= w_done_nxt;
         if (w_done_nxt)                                  r_state <= S_DONE;
         else if (w_lp_nxt)                               r_state <= S_FLUSH;
         else if (w_cnt_nxt != '0 || w_pop || r_vld_pipe[0]) r_state <= S_RUN;
         else                                             r_state <= S_IDLE;
      end
   end

   // Pop stage then plot register: pixel written at N strobes after N+2.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld_pipe <= '0;
         r_vga      <= '0;
         r_clip_cnt <= '0;
      end else begin
         r_vld_pipe <= {r_vld_pipe[0], w_pop};
         if (w_pop)         r_s1  <= w_head;
         if (r_vld_pipe[0]) r_vga <= r_s1;
         if (w_acc && w_clip && r_clip_cnt != 16'hFFFF) r_clip_cnt <= r_clip_cnt + 16'd1;
      end
   end

   assign vga_x      = r_vga.x;
   assign vga_y      = r_vga.y;
   assign vga_colour = r_vga.colour;
   assign vga_plot   = r_vld_pipe[1];
   assign done       = r_done;
   assign clip_count = r_clip_cnt;

endmodule

// File: tb/tb_pixel_clip_fifo.sv
// Scoreboard bench for pixel_clip_fifo: expected pixels are queued on acceptance
// and compared in order against each vga_plot strobe.
module tb_pixel_clip_fifo;
   import pixel_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [8:0]  in_x = '0;
   logic [7:0]  in_y = '0;
   logic [2:0]  in_colour = '0;
   logic        in_last = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        out_en = 1'b0;
   logic [7:0]  vga_x;
   logic [6:0]  vga_y;
   logic [2:0]  vga_colour;
   logic        vga_plot;
   logic        done;
   logic [15:0] clip_count;

   always #5 clk = ~clk;

   pixel_clip_fifo #(.DEPTH(8)) dut (
      .clk(clk), .rst(rst), .in_x(in_x), .in_y(in_y), .in_colour(in_colour),
      .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready), .out_en(out_en),
      .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
      .done(done), .clip_count(clip_count)
   );

   pixel_t sb[$];
   pixel_t mon_exp;
   int n_vec = 0, n_err = 0, n_plot = 0, n_done = 0, run = 0, max_run = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (vga_plot) begin
            n_plot++;
            run++;
            if (run > max_run) max_run = run;
            chk("sb_has_entry", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
               mon_exp = sb.pop_front();
               chk("pix", 32'({vga_x, vga_y, vga_colour}), 32'(mon_exp));
            end
         end else begin
            run = 0;
         end
         if (done) begin
            n_done++;
            chk("done_after_drain", 32'({vga_plot, sb.size() != 0}), 0);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input int x, input int y, input logic [2:0] c, input logic last,
                       output int edges);
      logic   acc;
      pixel_t p;
      in_x = 9'(x); in_y = 8'(y); in_colour = c; in_last = last; in_valid = 1'b1;
      edges = 0;
      do begin
         acc = in_ready;
         @(posedge clk); #1;
         edges++;
      end while (!acc && edges < 200);
      in_valid = 1'b0; in_last = 1'b0;
      if (!acc) chk("accept_timeout", 32'(acc), 1);
      else if (x >= 0 && x < 160 && y >= 0 && y < 120) begin
         p.x = 8'(x); p.y = 7'(y); p.colour = c;
         sb.push_back(p);
      end
   endtask

   task automatic wait_done(input int base, input int lim);
      for (int i = 0; i < lim; i++) begin
         if (n_done > base) break;
         tick(1);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(1);
      sb.delete();
      rst = 1'b0;
   endtask

   int e, bp, bd;
   int cx[4] = '{-1, 160, 0, 0};
   int cy[4] = '{0, 0, 120, -5};

   initial begin
      tick(2);
      chk("rst_ready", in_ready, 1);
      chk("rst_plot", vga_plot, 0);
      chk("rst_xyc", 32'({vga_x, vga_y, vga_colour}), 0);
      chk("rst_done", done, 0);
      chk("rst_clip", clip_count, 0);
      rst = 1'b0;

      // single pixel latency
      out_en = 1'b1;
      push(10, 20, 3'b101, 1'b0, e);
      chk("lat_n0", vga_plot, 0);
      tick(1); chk("lat_n1", vga_plot, 0);
      tick(1); chk("lat_n2", vga_plot, 1);
      chk("lat_x", vga_x, 10);
      chk("lat_y", vga_y, 20);
      chk("lat_c", vga_colour, 5);
      chk("lat_clip", clip_count, 0);
      tick(3);

      // off-screen on each edge
      bp = n_plot;
      for (int i = 0; i < 4; i++) begin
         chk("clip_ready", in_ready, 1);
         push(cx[i], cy[i], 3'b011, 1'b0, e);
      end
      tick(4);
      chk("clip_count4", clip_count, 4);
      chk("clip_noplot", n_plot - bp, 0);
      chk("clip_ready_after", in_ready, 1);

      // fill to full with output paused, then release
      out_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         push(i * 3, i + 1, 3'(i), 1'b0, e);
         chk("fill_edge", e, 1);
      end
      tick(3);
      chk("full_ready", in_ready, 0);
      chk("full_noplot", vga_plot, 0);
      max_run = 0;
      out_en = 1'b1;
      push(100, 50, 3'b111, 1'b0, e);
      chk("ninth_wait", e, 2);
      tick(12);
      chk("burst_run", max_run, 9);
      chk("pre_done", n_done, 0);

      // whole-screen fill
      bp = n_plot; bd = n_done;
      for (int y = 0; y < 120; y++)
         for (int x = 0; x < 160; x++)
            push(x, y, (x == 159 && y == 119) ? WHITE : 3'(x + y),
                 (x == 159 && y == 119), e);
      wait_done(bd, 100);
      chk("fill_plots", n_plot - bp, 19200);
      chk("fill_done", n_done - bd, 1);
      chk("fill_x", vga_x, 159);
      chk("fill_y", vga_y, 119);
      chk("fill_c", vga_colour, 7);
      tick(10);
      chk("fill_done_once", n_done - bd, 1);

      // clipped final pixel
      do_reset();
      out_en = 1'b0;
      bp = n_plot; bd = n_done;
      push(1, 2, 3'b001, 1'b0, e);
      push(3, 4, 3'b010, 1'b0, e);
      push(5, 6, 3'b100, 1'b0, e);
      push(200, 10, 3'b010, 1'b1, e);
      tick(5);
      chk("clast_hold", n_done - bd, 0);
      out_en = 1'b1;
      wait_done(bd, 50);
      chk("clast_plots", n_plot - bp, 3);
      chk("clast_done", n_done - bd, 1);
      chk("clast_clip", clip_count, 1);
      tick(10);
      chk("clast_done_once", n_done - bd, 1);

      // reset mid-drawing
      do_reset();
      out_en = 1'b0;
      for (int i = 0; i < 5; i++) push(20 + i, 30, 3'b110, 1'b0, e);
      push(-3, 5, 3'b001, 1'b1, e);
      chk("pre_rst_clip", clip_count, 1);
      rst = 1'b1;
      tick(1);
      chk("mrst_plot", vga_plot, 0);
      chk("mrst_ready", in_ready, 1);
      chk("mrst_clip", clip_count, 0);
      chk("mrst_done", done, 0);
      sb.delete();
      rst = 1'b0;
      bp = n_plot; bd = n_done;
      out_en = 1'b1;
      tick(20);
      chk("mrst_noplot", n_plot - bp, 0);
      chk("mrst_nodone", n_done - bd, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pixel_clip_fifo.md
Name: pixel_clip_fifo

Overview:
- Sits between pixel generators (fillscreen, circle, reuleaux) and the VGA adapter plot port.
- Accepts signed plot requests with a valid/ready handshake and discards any request that falls off the 160x120 screen.
- Buffers on-screen pixels in a small FIFO and drains one pixel per enabled cycle to vga_x/vga_y/vga_colour/vga_plot.
- Signals completion once the last pixel of a drawing has been written to the adapter.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2
SCREEN_W, 160, visible width in pixels
SCREEN_H, 120, visible height in pixels

Ports:
clk  input  1  system clock; single clock domain
rst  input  1  synchronous, active-high reset
in_x  input  9  signed pixel x; range -256..255
in_y  input  8  signed pixel y; range -128..127
in_colour  input  3  pixel colour
in_last  input  1  marks the final pixel of a drawing; qualified by in_valid
in_valid  input  1  request present
in_ready  output  1  block can accept a request this cycle
out_en  input  1  drain enable; 0 pauses output
vga_x  output  8  adapter x
vga_y  output  7  adapter y
vga_colour  output  3  adapter colour
vga_plot  output  1  adapter write strobe
done  output  1  one-cycle pulse when a drawing is complete
clip_count  output  16  number of requests dropped since reset; saturates at 65535

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: in_ready=1, vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, done=0, clip_count=0. The FIFO is emptied and the pending-last flag is cleared.
- Reset mid-operation: all queued pixels are discarded and no done pulse is produced for the interrupted drawing.
- Handshake: a request is accepted when in_valid && in_ready on a rising edge.
  - in_ready = (occupancy < DEPTH), registered from occupancy.
  - No same-cycle bypass when full: a read on a full FIFO does not raise in_ready in that cycle.
- Clipping: a request is clipped if in_x<0, in_x>=SCREEN_W, in_y<0 or in_y>=SCREEN_H (signed compares).
  - A clipped request is still accepted, but is not written to the FIFO.
  - Each clipped request increments clip_count by 1, saturating at 65535.
  - An on-screen request writes {in_x[7:0], in_y[6:0], in_colour} to the FIFO.
- Drain: in any cycle where out_en=1 and the FIFO is non-empty, the head entry is popped.
  - The popped entry is registered onto vga_x/y/colour with vga_plot=1 the following cycle.
  - Otherwise vga_plot=0, and vga_x/y/colour hold their last values.
- Latency: an on-screen pixel accepted at edge N into an empty FIFO with out_en=1 shows vga_plot=1 after edge N+2 (write at N, pop at N+1, plot register at N+2). Throughput is one pixel per cycle.
- Simultaneous push and pop: occupancy is unchanged; the FIFO pointers wrap modulo DEPTH.
- Last and done:
  - When an accepted request has in_last=1, whether clipped or not, last_pending is set.
  - done pulses high for exactly one cycle in the first cycle where last_pending=1, the FIFO is empty and vga_plot=0 (i.e., after the final strobe). last_pending clears on the same edge.
  - A new in_last accepted while last_pending=1 is merged: only one done pulse is produced.
- States: IDLE (empty, no last pending), RUN (occupancy>0 or output strobe active), FLUSH (last_pending, still draining), DONE (one-cycle pulse state), then back to IDLE.

Decomposition:
- Package pixel_pkg holds:
  - typedef pixel_t {x[7:0], y[6:0], colour[2:0]};
  - constants SCREEN_W=160, SCREEN_H=120;
  - colour constants BLACK=3'b000, WHITE=3'b111.
- One sub-module, sync_fifo: parameterised width/depth, with push, pop, full, empty and count. The top level holds the clip logic, output register, done FSM and counter.

Test Plan:
- Reset, then push (10,20,3'b101) with out_en=1 -> 2 cycles later vga_plot=1, vga_x=10, vga_y=20, vga_colour=5; clip_count=0.
- Push x=-1, x=160, y=120, y=-5, one each -> no vga_plot; clip_count=4; in_ready stays 1.
- out_en=0, push 9 pixels -> 8 accepted, in_ready=0 on the 9th. Then set out_en=1 -> 8 consecutive plot cycles in FIFO order, and the 9th is accepted after the first pop.
- Full 160x120 fill (19200 pixels, last at (159,119) white, in_last=1) -> 19200 strobes; final vga_x=159, vga_y=119, vga_colour=7; exactly one done pulse after the last strobe.
- Last pixel clipped (x=200, in_last=1) after 3 queued on-screen pixels -> 3 strobes, then done pulses once; clip_count=1.
- Assert rst with 5 pixels queued -> next cycle vga_plot=0, in_ready=1, clip_count=0; no done pulse and no further strobes.
